// File: rtl/axis2fifo_packer_pkg.sv
// Shared state encoding and sizing helpers for the AXI4-Stream video to FIFO
// packer and its word-packing datapath.
package axis2fifo_packer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_ACTIVE,
    ST_PAD,
    ST_DROP,
    ST_FLUSH
  } state_e;

  // Number of bits needed to index `value` items (ceil(log2(value))).
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (((value - 1) >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_ADATA_PIXELS = 4;
  localparam int DEF_LANE_W       = clogb2(DEF_ADATA_PIXELS);

endpackage

// File: rtl/axis2fifo_packer_if.sv
// Pixel-per-beat AXI4-Stream video bus (tuser = SOF, tlast = EOL).
interface axis2fifo_packer_if #(
  parameter int C_PIXEL_WIDTH = 8
);
  logic                     tvalid;
  logic [C_PIXEL_WIDTH-1:0] tdata;
  logic                     tuser;
  logic                     tlast;
  logic                     tready;

  modport master (output tvalid, tdata, tuser, tlast, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/axis2fifo_packer_pixel_word_packer.sv
// Lane counter, word assembly and the single-word output register that
// presents completed words to the FIFO with an adv handshake.
module pixel_word_packer
  import axis2fifo_packer_pkg::*;
#(
  parameter int C_PIXEL_WIDTH  = 8,
  parameter int C_ADATA_PIXELS = DEF_ADATA_PIXELS,
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_LANE_W       = DEF_LANE_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush_n,
  input  logic                     fill,
  input  logic                     restart,
  input  logic [C_PIXEL_WIDTH-1:0] pix,
  input  logic                     fifo_full,
  output logic                     adv,
  output logic                     fifo_wr_en,
  output logic [C_DATA_WIDTH-1:0]  fifo_din
);

  logic [C_LANE_W-1:0]     lane_q, lane_d, lane_eff;
  logic [C_DATA_WIDTH-1:0] data_q, data_d, word;
  logic [C_DATA_WIDTH-1:0] fifo_din_q, fifo_din_d;
  logic                    out_valid_q, out_valid_d;
  logic                    word_done;

  assign fifo_wr_en = out_valid_q & ~fifo_full;
  assign adv        = ~out_valid_q | ~fifo_full;
  assign fifo_din   = fifo_din_q;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    lane_eff    = restart ? '0 : lane_q;
    word        = data_q;
    word[int'(lane_eff)*C_PIXEL_WIDTH +: C_PIXEL_WIDTH] = pix;
    word_done   = fill & (lane_eff == C_LANE_W'(C_ADATA_PIXELS - 1));
    data_d      = data_q;
    lane_d      = lane_eff;
    fifo_din_d  = fifo_din_q;
    out_valid_d = out_valid_q;

    if (fifo_wr_en) out_valid_d = 1'b0;
    if (fill) begin
      data_d = word;
      lane_d = lane_eff + C_LANE_W'(1);
    end
    // A completing word reloads the output register even while the old one drains.
    if (word_done) begin
      fifo_din_d  = word;
      out_valid_d = 1'b1;
    end
    if (!flush_n) begin
      lane_d      = '0;
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the assembly
  // register is reset too so fifo_din never shows stale pixels after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lane_q      <= '0;
      data_q      <= '0;
      fifo_din_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      data_q      <= data_d;
      fifo_din_q  <= fifo_din_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: rtl/axis2fifo_packer.sv
// Frame-geometry enforcing front end of the S2MM writer: pads short lines,
// truncates long ones and restarts on a mid-frame SOF, packing pixels into FIFO words.
module axis2fifo_packer
  import axis2fifo_packer_pkg::*;
#(
  parameter int C_PIXEL_WIDTH  = 8,
  parameter int C_ADATA_PIXELS = 4,
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_IMG_WBITS    = 12,
  parameter int C_IMG_HBITS    = 12
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    soft_resetn,
  input  logic [C_IMG_WBITS-1:0]  img_width,
  input  logic [C_IMG_HBITS-1:0]  img_height,
  axis2fifo_packer_if.slave       s_axis,
  output logic                    fifo_wr_en,
  output logic [C_DATA_WIDTH-1:0] fifo_din,
  input  logic                    fifo_full,
  output logic                    frame_done,
  output logic                    sof_err,
  output logic                    line_err
);

  state_e                   state_q, state_d;
  logic [C_IMG_WBITS-1:0]   col_q, col_d, width_q, width_d;
  logic [C_IMG_HBITS-1:0]   row_q, row_d, height_q, height_d;
  logic                     frame_done_q, frame_done_d;
  logic                     sof_err_q, sof_err_d;
  logic                     line_err_q, line_err_d;
  logic                     tready, beat, adv, fill, restart, eol, sof_take;
  logic                     col_last, row_last;
  logic [C_PIXEL_WIDTH-1:0] pix;

  assign col_last   = (col_q == width_q - C_IMG_WBITS'(1));
  assign row_last   = (row_q == height_q - C_IMG_HBITS'(1));
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
  assign line_err   = line_err_q;

  // In DROP only an SOF beat needs a free lane, so only that beat waits on adv.
  always_comb begin
    tready = 1'b0;
    case (state_q)
      ST_WAIT_SOF: tready = 1'b1;
      ST_ACTIVE:   tready = adv;
      ST_DROP:     tready = adv | ~s_axis.tuser;
      default:     tready = 1'b0;
    endcase
    if (!soft_resetn) tready = 1'b0;
  end

  assign s_axis.tready = tready;
  assign beat          = s_axis.tvalid & tready;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    width_d      = width_q;
    height_d     = height_q;
    fill         = 1'b0;
    restart      = 1'b0;
    pix          = s_axis.tdata;
    eol          = 1'b0;
    sof_take     = 1'b0;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    line_err_d   = 1'b0;

    case (state_q)
      ST_IDLE:     state_d  = ST_WAIT_SOF;
      ST_WAIT_SOF: sof_take = beat & s_axis.tuser;
      ST_ACTIVE: begin
        if (beat & s_axis.tuser) begin
          sof_take  = 1'b1;
          sof_err_d = 1'b1;
        end else if (beat) begin
          fill  = 1'b1;
          col_d = col_q + C_IMG_WBITS'(1);
          if (col_last) begin
            eol = 1'b1;
            if (!s_axis.tlast) begin
              line_err_d = 1'b1;
              state_d    = ST_DROP;
            end
          end else if (s_axis.tlast) begin
            line_err_d = 1'b1;
            state_d    = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (adv) begin
          fill  = 1'b1;
          pix   = '0;
          col_d = col_q + C_IMG_WBITS'(1);
          if (col_last) begin
            eol     = 1'b1;
            state_d = ST_ACTIVE;
          end
        end
      end
      ST_DROP: begin
        if (beat & s_axis.tuser) begin
          sof_take  = 1'b1;
          sof_err_d = 1'b1;
        end else if (beat & s_axis.tlast) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_FLUSH: begin
        // Nothing completes in FLUSH, so the pending word is the frame's last.
        if (fifo_wr_en) begin
          frame_done_d = 1'b1;
          state_d      = ST_WAIT_SOF;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (eol) begin
      col_d = '0;
      if (row_last) begin
        row_d   = '0;
        state_d = ST_FLUSH;
      end else begin
        row_d = row_q + C_IMG_HBITS'(1);
      end
    end

    // An SOF beat is column 0 of a fresh frame, regardless of tlast.
    if (sof_take) begin
      fill     = 1'b1;
      restart  = 1'b1;
      col_d    = C_IMG_WBITS'(1);
      row_d    = '0;
      width_d  = img_width;
      height_d = img_height;
      state_d  = ST_ACTIVE;
    end

    if (!soft_resetn) begin
      state_d      = ST_IDLE;
      col_d        = '0;
      row_d        = '0;
      fill         = 1'b0;
      frame_done_d = 1'b0;
      sof_err_d    = 1'b0;
      line_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      width_q      <= '0;
      height_q     <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      width_q      <= width_d;
      height_q     <= height_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      line_err_q   <= line_err_d;
    end
  end

  pixel_word_packer #(
    .C_PIXEL_WIDTH (C_PIXEL_WIDTH),
    .C_ADATA_PIXELS(C_ADATA_PIXELS),
    .C_DATA_WIDTH  (C_DATA_WIDTH),
    .C_LANE_W      (clogb2(C_ADATA_PIXELS))
  ) u_packer (
    .clk       (clk),
    .resetn    (resetn),
    .flush_n   (soft_resetn),
    .fill      (fill),
    .restart   (restart),
    .pix       (pix),
    .fifo_full (fifo_full),
    .adv       (adv),
    .fifo_wr_en(fifo_wr_en),
    .fifo_din  (fifo_din)
  );

endmodule

// File: tb/tb_axis2fifo_packer.sv
// Directed bench for axis2fifo_packer: nominal, garbage, short/long line,
// backpressure, mid-frame SOF and soft reset, with hand-computed words.
module tb_axis2fifo_packer;

  localparam int PW = 8;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int WB = 12;
  localparam int HB = 12;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          soft_resetn = 1'b1;
  logic          fifo_full = 1'b0;
  logic [WB-1:0] img_width = WB'(8);
  logic [HB-1:0] img_height = HB'(2);
  logic          fifo_wr_en, frame_done, sof_err, line_err;
  logic [DW-1:0] fifo_din;

  axis2fifo_packer_if #(.C_PIXEL_WIDTH(PW)) s_axis ();

  axis2fifo_packer #(
    .C_PIXEL_WIDTH (PW),
    .C_ADATA_PIXELS(NP),
    .C_DATA_WIDTH  (DW),
    .C_IMG_WBITS   (WB),
    .C_IMG_HBITS   (HB)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .soft_resetn(soft_resetn),
    .img_width  (img_width),
    .img_height (img_height),
    .s_axis     (s_axis),
    .fifo_wr_en (fifo_wr_en),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .frame_done (frame_done),
    .sof_err    (sof_err),
    .line_err   (line_err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] wr_log[$];
  logic [DW-1:0] exp_q[$];
  int            fd_cnt = 0, se_cnt = 0, le_cnt = 0;
  int            base, fd0, se0, le0;

  // Outputs are registered (or combinational from registers and fifo_full,
  // which only moves just after posedge), so the negedge value is what the next edge sees.
  always @(negedge clk) begin
    if (fifo_wr_en) wr_log.push_back(fifo_din);
    if (frame_done) fd_cnt++;
    if (sof_err)    se_cnt++;
    if (line_err)   le_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [PW-1:0] d, input logic u, input logic l);
    bit ok;
    ok = 1'b0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    s_axis.tuser  = u;
    s_axis.tlast  = l;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = s_axis.tready;
    end
    if (!ok) check("tready_wait", 32'(s_axis.tready), 32'd1);
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic send_line(input logic [PW-1:0] start, input int n, input logic sof);
    for (int i = 0; i < n; i++)
      send(start + PW'(i), sof && (i == 0), i == n - 1);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    base = wr_log.size();
    fd0  = fd_cnt;
    se0  = se_cnt;
    le0  = le_cnt;
  endtask

  task automatic expect_frame(input string tag, input int fd, input int se, input int le);
    check({tag, "_count"}, 32'(wr_log.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < wr_log.size())
        check($sformatf("%s_w%0d", tag, i), wr_log[base + i], exp_q[i]);
    check({tag, "_frame_done"}, 32'(fd_cnt - fd0), 32'(fd));
    check({tag, "_sof_err"},    32'(se_cnt - se0), 32'(se));
    check({tag, "_line_err"},   32'(le_cnt - le0), 32'(le));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tuser  = 1'b0;
    s_axis.tlast  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready",     32'(s_axis.tready), 32'd0);
    check("rst_wr_en",      32'(fifo_wr_en),    32'd0);
    check("rst_din",        fifo_din,           32'd0);
    check("rst_frame_done", 32'(frame_done),    32'd0);
    check("rst_sof_err",    32'(sof_err),       32'd0);
    check("rst_line_err",   32'(line_err),      32'd0);
    resetn = 1'b1;
    settle(1);
    check("wait_sof_tready", 32'(s_axis.tready), 32'd1);

    // Nominal 8x2 frame, write must follow each 4th pixel by one cycle
    exp_q = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
    snap();
    for (int i = 0; i < 16; i++) begin
      send(PW'(i + 1), i == 0, (i == 7) || (i == 15));
      if (i % 4 == 3) begin
        check($sformatf("nom_wr_en%0d", i / 4), 32'(fifo_wr_en), 32'd1);
        check($sformatf("nom_din%0d", i / 4),   fifo_din,         exp_q[i / 4]);
      end
    end
    settle(4);
    expect_frame("nom", 1, 0, 0);

    // Leading garbage without tuser is discarded
    snap();
    send(8'hAA, 1'b0, 1'b0);
    send(8'hBB, 1'b0, 1'b1);
    send(8'hCC, 1'b0, 1'b0);
    send_line(8'h01, 8, 1'b1);
    send_line(8'h09, 8, 1'b0);
    settle(4);
    expect_frame("garbage", 1, 0, 0);

    // Short line: 5 pixels then zero padding
    exp_q = '{32'h04030201, 32'h00000005, 32'h0C0B0A09, 32'h100F0E0D};
    snap();
    send_line(8'h01, 5, 1'b1);
    send_line(8'h09, 8, 1'b0);
    settle(4);
    expect_frame("short", 1, 0, 1);

    // Long line: pixels 9 and 10 truncated
    exp_q = '{32'h04030201, 32'h08070605, 32'h14131211, 32'h18171615};
    snap();
    send_line(8'h01, 10, 1'b1);
    send_line(8'h11, 8, 1'b0);
    settle(4);
    expect_frame("long", 1, 0, 1);

    // Backpressure: fifo_full for 6 cycles with a word pending
    img_height = HB'(1);
    exp_q = '{32'h24232221, 32'h28272625};
    snap();
    send(8'h21, 1'b1, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h23, 1'b0, 1'b0);
    send(8'h24, 1'b0, 1'b0);
    fifo_full = 1'b1;
    #1;
    check("bp_tready", 32'(s_axis.tready), 32'd0);
    check("bp_wr_en",  32'(fifo_wr_en),    32'd0);
    fork
      begin
        send(8'h25, 1'b0, 1'b0);
        send(8'h26, 1'b0, 1'b0);
        send(8'h27, 1'b0, 1'b0);
        send(8'h28, 1'b0, 1'b1);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        check("bp_held_wr_count", 32'(wr_log.size() - base), 32'd0);
        fifo_full = 1'b0;
        #1;
        check("bp_resume_wr_en", 32'(fifo_wr_en), 32'd1);
        check("bp_resume_din",   fifo_din,        32'h24232221);
      end
    join
    settle(4);
    expect_frame("bp", 1, 0, 0);

    // Mid-frame SOF at row 1 column 2 restarts with height 1
    img_height = HB'(2);
    exp_q = '{32'h34333231, 32'h38373635, 32'h44434241, 32'h48474645};
    snap();
    send_line(8'h31, 8, 1'b1);
    send(8'h39, 1'b0, 1'b0);
    send(8'h3A, 1'b0, 1'b0);
    img_height = HB'(1);
    send_line(8'h41, 8, 1'b1);
    settle(4);
    expect_frame("midsof", 1, 1, 0);

    // Soft reset drops a partial word and returns to WAIT_SOF
    exp_q = '{32'h64636261, 32'h68676665};
    snap();
    send(8'h51, 1'b1, 1'b0);
    send(8'h52, 1'b0, 1'b0);
    soft_resetn = 1'b0;
    #1;
    check("srst_tready_low", 32'(s_axis.tready), 32'd0);
    @(posedge clk);
    #1;
    soft_resetn = 1'b1;
    #1;
    check("srst_wr_en",      32'(fifo_wr_en),    32'd0);
    check("srst_idle_tready", 32'(s_axis.tready), 32'd0);
    settle(1);
    check("srst_wait_tready", 32'(s_axis.tready), 32'd1);
    send_line(8'h61, 8, 1'b1);
    settle(4);
    expect_frame("srst", 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
